// File: rtl/fpu_pkg.sv
// Shared FPU front-end types and constants.
package fpu_pkg;
   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} fpu_op_t;
   localparam int FSUB_LAT = 3;
   localparam int OWNER_W  = 1;
endpackage

// File: rtl/fpu_rsp_fifo.sv
// Per-requester result FIFO; head reads as zero while empty.
module fpu_rsp_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [31:0]                push_data,
   input  logic                       pop,
   output logic [31:0]                pop_data,
   output logic [$clog2(DEPTH+1)-1:0] occ
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic [CW-1:0] occ_d, occ_q;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      do_pop   = pop && (occ_q != '0);
      wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      occ_d    = occ_q + CW'(push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign occ      = occ_q;

   // Credit accounting must make this unreachable.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && (occ_q == DEPTH_C)));
endmodule

// File: rtl/fsub.sv
// Three-stage single-precision subtractor: result = op1 - op2, round-to-nearest-even,
// denormal inputs and results flushed to zero.
module fsub (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic [31:0] result
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic [31:0] big, sml, opb;
   logic        sgn_p0_d, sgn_p0_q, sub_p0_d, sub_p0_q, zsg_p0_d, zsg_p0_q, spec_p0_d, spec_p0_q;
   logic [7:0]  exp_p0_d, exp_p0_q, dif_p0_d, dif_p0_q;
   logic [23:0] mb_p0_d, mb_p0_q, ms_p0_d, ms_p0_q;
   logic [31:0] spv_p0_d, spv_p0_q;
   logic [26:0] al, lost;
   logic [27:0] sum_p1_d, sum_p1_q;
   logic        sgn_p1_q, zsg_p1_q, spec_p1_q;
   logic [7:0]  exp_p1_q;
   logic [31:0] spv_p1_q;
   logic [26:0] nrm;
   logic [24:0] rnd;
   logic [22:0] mnt;
   logic        rup;
   int          e, lz;
   logic [31:0] result_d, result_q;

   // p0: negate op2, order operands by magnitude
   always_comb begin
      opb = {~op2[31], op2[30:0]};
      if (opb[30:0] > op1[30:0]) begin
         big = opb;
         sml = op1;
      end else begin
         big = op1;
         sml = opb;
      end
      sgn_p0_d  = big[31];
      sub_p0_d  = big[31] ^ sml[31];
      zsg_p0_d  = big[31] & sml[31];
      exp_p0_d  = big[30:23];
      dif_p0_d  = big[30:23] - sml[30:23];
      mb_p0_d   = (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
      ms_p0_d   = (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
      spec_p0_d = (big[30:23] == 8'hFF);
      spv_p0_d  = ((big[22:0] != 23'd0) || ((sml[30:0] == big[30:0]) && sub_p0_d)) ? QNAN : big;
   end

   // p1: align the smaller operand with guard/round/sticky, then add or subtract
   always_comb begin
      lost = '0;
      if (dif_p0_q > 8'd26) begin
         al = {26'd0, |ms_p0_q};
      end else begin
         lost = {ms_p0_q, 3'b000} << (8'd27 - dif_p0_q);
         al   = ({ms_p0_q, 3'b000} >> dif_p0_q) | {26'd0, |lost};
      end
      sum_p1_d = sub_p0_q ? ({1'b0, mb_p0_q, 3'b000} - {1'b0, al})
                          : ({1'b0, mb_p0_q, 3'b000} + {1'b0, al});
   end

   // p2: normalise, round, pack
   always_comb begin
      lz  = 0;
      nrm = sum_p1_q[26:0];
      e   = int'(exp_p1_q);
      if (sum_p1_q[27]) begin
         nrm = {sum_p1_q[27:2], sum_p1_q[1] | sum_p1_q[0]};
         e   = int'(exp_p1_q) + 1;
      end else begin
         for (int i = 0; i <= 26; i++) if (sum_p1_q[i]) lz = 26 - i;
         nrm = sum_p1_q[26:0] << lz;
         e   = int'(exp_p1_q) - lz;
      end
      rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
      rnd = {1'b0, nrm[26:3]} + {24'd0, rup};
      mnt = rnd[24] ? rnd[23:1] : rnd[22:0];
      if (rnd[24]) e = e + 1;
      if (spec_p1_q)               result_d = spv_p1_q;
      else if (sum_p1_q == 28'd0)  result_d = {zsg_p1_q, 31'd0};
      else if (e >= 255)           result_d = {sgn_p1_q, 8'hFF, 23'd0};
      else if (e <= 0)             result_d = {sgn_p1_q, 31'd0};
      else                         result_d = {sgn_p1_q, e[7:0], mnt};
   end

   always_ff @(posedge clk) begin
      sgn_p0_q  <= sgn_p0_d;
      sub_p0_q  <= sub_p0_d;
      zsg_p0_q  <= zsg_p0_d;
      spec_p0_q <= spec_p0_d;
      exp_p0_q  <= exp_p0_d;
      dif_p0_q  <= dif_p0_d;
      mb_p0_q   <= mb_p0_d;
      ms_p0_q   <= ms_p0_d;
      spv_p0_q  <= spv_p0_d;
      sum_p1_q  <= sum_p1_d;
      sgn_p1_q  <= sgn_p0_q;
      zsg_p1_q  <= zsg_p0_q;
      spec_p1_q <= spec_p0_q;
      exp_p1_q  <= exp_p0_q;
      spv_p1_q  <= spv_p0_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) result_q <= '0;
      else        result_q <= result_d;
   end

   assign result = result_q;
endmodule

// File: rtl/fpu_addsub_share.sv
// Shares one fsub pipeline between two requesters with round-robin issue, a valid/owner
// tracker and credit-limited per-requester result FIFOs.
module fpu_addsub_share
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int LAT   = FSUB_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  fpu_op_t     req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  fpu_op_t     req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_data,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_data,
   output logic        busy
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic               vld;
      logic [OWNER_W-1:0] owner;
   } trk_t;

   trk_t          trk_d [LAT];
   trk_t          trk_q [LAT];
   logic          last_grant_d, last_grant_q;
   logic [CW-1:0] inflight0_d, inflight0_q, inflight1_d, inflight1_q;
   logic [CW-1:0] occ0, occ1;
   logic [CW:0]   cnt0, cnt1;
   logic          elig0, elig1, grant0, grant1, grant_any;
   logic          push0, push1, any_vld;
   logic [31:0]   fs_op1, fs_op2, fs_res, sel_b;

   assign cnt0  = {1'b0, occ0} + {1'b0, inflight0_q};
   assign cnt1  = {1'b0, occ1} + {1'b0, inflight1_q};
   assign elig0 = reset && req0_valid && (cnt0 < DEPTH_C);
   assign elig1 = reset && req1_valid && (cnt1 < DEPTH_C);

   // Arbitration and operand steering; add is issued as a - (-b).
   always_comb begin
      if (elig0 && elig1) begin
         grant0 = last_grant_q;
         grant1 = ~last_grant_q;
      end else begin
         grant0 = elig0;
         grant1 = elig1;
      end
      grant_any    = grant0 | grant1;
      last_grant_d = grant_any ? grant1 : last_grant_q;
      fs_op1       = '0;
      fs_op2       = '0;
      sel_b        = grant1 ? req1_b : req0_b;
      if (grant_any) begin
         fs_op1 = grant1 ? req1_a : req0_a;
         fs_op2 = ((grant1 ? req1_op : req0_op) == OP_SUB) ? sel_b : {~sel_b[31], sel_b[30:0]};
      end
   end

   always_comb begin
      trk_d[0].vld   = grant_any;
      trk_d[0].owner = OWNER_W'(grant1);
      for (int i = 1; i < LAT; i++) trk_d[i] = trk_q[i-1];
      push0       = trk_q[LAT-1].vld && (trk_q[LAT-1].owner == '0);
      push1       = trk_q[LAT-1].vld && (trk_q[LAT-1].owner != '0);
      inflight0_d = inflight0_q + CW'(grant0) - CW'(push0);
      inflight1_d = inflight1_q + CW'(grant1) - CW'(push1);
      any_vld     = 1'b0;
      for (int i = 0; i < LAT; i++) any_vld = any_vld | trk_q[i].vld;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LAT; i++) trk_q[i] <= '0;
         last_grant_q <= 1'b1;
         inflight0_q  <= '0;
         inflight1_q  <= '0;
      end else begin
         for (int i = 0; i < LAT; i++) trk_q[i] <= trk_d[i];
         last_grant_q <= last_grant_d;
         inflight0_q  <= inflight0_d;
         inflight1_q  <= inflight1_d;
      end
   end

   fsub u_fsub (
      .clk    (clk),
      .reset  (reset),
      .op1    (fs_op1),
      .op2    (fs_op2),
      .result (fs_res)
   );

   fpu_rsp_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk       (clk),
      .reset     (reset),
      .push      (push0),
      .push_data (fs_res),
      .pop       (rsp0_ready),
      .pop_data  (rsp0_data),
      .occ       (occ0)
   );

   fpu_rsp_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk       (clk),
      .reset     (reset),
      .push      (push1),
      .push_data (fs_res),
      .pop       (rsp1_ready),
      .pop_data  (rsp1_data),
      .occ       (occ1)
   );

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = (occ0 != '0);
   assign rsp1_valid = (occ1 != '0);
   assign busy       = any_vld || rsp0_valid || rsp1_valid;
endmodule

// File: tb/tb_fpu_addsub_share.sv
// Randomised bench for fpu_addsub_share against an outstanding-operation queue model.
module tb_fpu_addsub_share;
   import fpu_pkg::*;

   localparam int DEPTH = 2;
   localparam int LAT   = FSUB_LAT;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   fpu_op_t     req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;
   logic        busy;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          ia0, ib0, ia1, ib1;
   logic        acc0, acc1, o0, o1, mlast;
   logic [31:0] qv0[$], qv1[$];
   int          qt0[$], qt1[$];

   always #5 clk = ~clk;

   fpu_addsub_share #(.DEPTH(DEPTH), .LAT(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data),
      .busy       (busy)
   );

   // Exact IEEE single encoding of a small integer.
   function automatic logic [31:0] int2fp(input int x);
      logic [31:0] m;
      int          p;
      if (x == 0) return 32'd0;
      m = (x < 0) ? 32'(-x) : 32'(x);
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      m = m << (23 - p);
      return {(x < 0), 8'(127 + p), m[22:0]};
   endfunction

   function automatic logic [31:0] ref_res(input int a, input int b, input fpu_op_t op);
      return int2fp((op == OP_SUB) ? (a - b) : (a + b));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_ops();
      req0_a = int2fp(ia0);
      req0_b = int2fp(ib0);
      req1_a = int2fp(ia1);
      req1_b = int2fp(ib1);
   endtask

   function automatic int rnd_int();
      return int'($urandom_range(2000)) - 1000;
   endfunction

   // One clock cycle: compare DUT outputs to the model, then advance the model.
   task automatic step();
      logic e0, e1, g0, g1, x0, x1;
      drive_ops();
      #2;
      e0 = req0_valid && (qv0.size() < DEPTH);
      e1 = req1_valid && (qv1.size() < DEPTH);
      g0 = e0 && (!e1 || mlast);
      g1 = e1 && !g0;
      x0 = 1'b0;
      x1 = 1'b0;
      if (qt0.size() > 0) x0 = (cyc >= qt0[0] + LAT + 1);
      if (qt1.size() > 0) x1 = (cyc >= qt1[0] + LAT + 1);
      o0 = req0_ready;
      o1 = req1_ready;
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      check("rsp0_valid", 32'(rsp0_valid), 32'(x0));
      check("rsp1_valid", 32'(rsp1_valid), 32'(x1));
      if (x0) check("rsp0_data", rsp0_data, qv0[0]);
      if (x1) check("rsp1_data", rsp1_data, qv1[0]);
      check("busy", 32'(busy), 32'((qv0.size() + qv1.size()) != 0));
      if (x0 && rsp0_ready) begin void'(qv0.pop_front()); void'(qt0.pop_front()); end
      if (x1 && rsp1_ready) begin void'(qv1.pop_front()); void'(qt1.pop_front()); end
      if (g0) begin qv0.push_back(ref_res(ia0, ib0, req0_op)); qt0.push_back(cyc); end
      if (g1) begin qv1.push_back(ref_res(ia1, ib1, req1_op)); qt1.push_back(cyc); end
      if (g0 || g1) mlast = g1;
      acc0 = g0;
      acc1 = g1;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Random requests that hold until accepted; random response backpressure.
   task automatic rand_step(input int pv0, input int pv1, input int pr0, input int pr1);
      if (!req0_valid || acc0) begin
         req0_valid = (int'($urandom_range(99)) < pv0);
         req0_op    = fpu_op_t'($urandom_range(1));
         ia0        = rnd_int();
         ib0        = rnd_int();
      end
      if (!req1_valid || acc1) begin
         req1_valid = (int'($urandom_range(99)) < pv1);
         req1_op    = fpu_op_t'($urandom_range(1));
         ia1        = rnd_int();
         ib1        = rnd_int();
      end
      rsp0_ready = (int'($urandom_range(99)) < pr0);
      rsp1_ready = (int'($urandom_range(99)) < pr1);
      step();
   endtask

   task automatic drain();
      int n;
      n = 0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      while ((req0_valid || req1_valid || busy) && n < 200) begin
         step();
         if (acc0) req0_valid = 1'b0;
         if (acc1) req1_valid = 1'b0;
         n++;
      end
      check("drain_idle", 32'(busy | req0_valid | req1_valid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
      check({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
      check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
      check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
      check({tag, "_rsp0_data"}, rsp0_data, 32'd0);
      check({tag, "_rsp1_data"}, rsp1_data, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic model_clear();
      qv0.delete(); qt0.delete(); qv1.delete(); qt1.delete();
      mlast = 1'b1;
      acc0  = 1'b0;
      acc1  = 1'b0;
   endtask

   initial begin
      int waits, n0, n1;
      reset      = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_op    = OP_ADD;
      req1_op    = OP_ADD;
      ia0 = 0; ib0 = 0; ia1 = 0; ib1 = 0;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      model_clear();
      drive_ops();
      #1 reset = 1'b0;
      #2 check_all_zero("rst");
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;

      // single add on requester 0
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_op = OP_ADD; ia0 = 1; ib0 = 2;
      step();
      check("add_accept", 32'(o0), 32'd1);
      req0_valid = 1'b0;
      waits = 0;
      while (!rsp0_valid && waits < 10) begin step(); waits++; end
      check("add_latency", waits, 3);
      check("add_data", rsp0_data, 32'h4040_0000);
      step();

      // single sub on requester 1
      req1_valid = 1'b1; req1_op = OP_SUB; ia1 = 3; ib1 = 1;
      step();
      check("sub_accept", 32'(o1), 32'd1);
      req1_valid = 1'b0;
      waits = 0;
      while (!rsp1_valid && waits < 10) begin step(); waits++; end
      check("sub_data", rsp1_data, 32'h4000_0000);
      check("sub_rsp0_idle", 32'(rsp0_valid), 32'd0);
      step();

      // both requesting every cycle, both draining
      for (int i = 0; i < 16; i++) begin
         rand_step(100, 100, 100, 100);
         if (i < 4) check("alt_grant0", 32'(o0), 32'((i % 2) == 0));
      end
      drain();

      // backpressure on requester 0
      n0 = 0; n1 = 0;
      for (int i = 0; i < 12; i++) begin
         rand_step(100, 100, 0, 100);
         n0 += int'(o0); n1 += int'(o1);
      end
      check("bp_accepts0", n0, 2);
      check("bp_req1_served", 32'(n1 >= 3), 32'd1);
      n0 = 0;
      for (int i = 0; i < 20; i++) begin
         rand_step(100, 100, 100, 100);
         n0 += int'(o0);
      end
      check("bp_resume0", 32'(n0 >= 5), 32'd1);
      drain();

      // reset with two operations in flight
      req0_valid = 1'b1; req0_op = OP_ADD; ia0 = 5; ib0 = 7;
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = OP_SUB; ia1 = 9; ib1 = 4;
      step();
      req1_valid = 1'b0;
      step();
      reset = 1'b0;
      #1 check_all_zero("midrst");
      model_clear();
      @(posedge clk); @(posedge clk); cyc += 2; #1;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) step();
      check("post_rst_busy", 32'(busy), 32'd0);
      req0_valid = 1'b1; req0_op = OP_SUB; ia0 = 10; ib0 = 10;
      req1_valid = 1'b1; req1_op = OP_ADD; ia1 = -6; ib1 = 2;
      step();
      check("post_rst_tie0", 32'(o0), 32'd1);
      drain();

      // long random valid/ready run
      for (int i = 0; i < 10000; i++) rand_step(70, 70, 60, 60);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
